divider_sequential: RTL and testbench
=====================================

# divider_sequential

Multi-cycle unsigned integer divider: the inverse operation to the team's combinational half-adder multipliers. Takes a `WIDTH`-bit dividend and divisor and produces quotient and remainder by restoring shift-subtract, one quotient bit per clock. Sits next to the multiplier blocks as the arithmetic unit for division, behind a start/busy/done handshake so a controller or testbench can sequence operations.

## Interface
- `WIDTH`, default 4: operand, quotient and remainder width in bits; legal range 2..32.

- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: one clock domain; reset is synchronous and active-high.
- `start`, input, 1: request a division; sampled only in IDLE.
- `num1`, input, WIDTH: dividend; captured on the accepting edge.
- `num2`, input, WIDTH: divisor; captured on the accepting edge.
- `busy`, output, 1: high while an operation is in RUN.
- `done`, output, 1: single-cycle pulse; results are valid.
- `quotient`, output, WIDTH: registered quotient; holds until the next accepted start.
- `remainder`, output, WIDTH: registered remainder; holds until the next accepted start.
- `div_by_zero`, output, 1: registered flag for the last operation; set when the divisor was 0.

## Operation
- States are IDLE, RUN and DONE.
- Reset:
  - Forces IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - Clears internal counter and partial remainder.
- IDLE:
  - `start`=1 latches `num1` into the dividend shift register and `num2` into the divisor register.
  - Clears the (WIDTH+1)-bit partial remainder and sets bit counter = WIDTH-1.
  - If `num2`≠0, go to RUN. If `num2`=0, go to DONE.
- RUN, once per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial = partial remainder − divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative (MSB 0), keep trial and shift in quotient bit 1; otherwise restore and shift in 0.
  - When counter = 0, write `quotient` and `remainder` (low WIDTH bits) and go to DONE; else decrement the counter.
- DONE:
  - `done`=1 for exactly one cycle, then go to IDLE.
  - Zero-divisor path: `quotient` = all ones, `remainder` = `num1`, `div_by_zero`=1.
  - Normal path: `div_by_zero`=0.
- `start` in RUN or DONE is ignored; it is not queued.
- `num1`/`num2` changes after acceptance have no effect.
- Reset mid-operation wins over everything: the operation is abandoned and no `done` is produced.
- Result invariant for divisor ≠ 0: `num1` = `quotient`·`num2` + `remainder`, with `remainder` < `num2`.

## Timing
- Accepting edge k (IDLE, `start`=1): `busy`=1 from after edge k through edge k+WIDTH.
- Results update on edge k+WIDTH. `done`=1 in the cycle after edge k+WIDTH (latency WIDTH+1 edges to `done` falling back to 0 at k+WIDTH+1).
- Zero divisor: results update on edge k+1, `done`=1 in the cycle after edge k+1, `busy` never asserts.
- Earliest next acceptance is edge k+WIDTH+2, since IDLE is reached at k+WIDTH+1.
- Throughput is one division per WIDTH+2 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `DIVIDER_DISPLAY_EN`:
  - Defined: on every `done` pulse the block prints via `$display` `"<num1> / <num2> = <quotient> r <remainder>"` in binary, with `" DIV0"` appended when `div_by_zero`.
  - Undefined: no simulation output; RTL is otherwise identical.
- The display is never synthesised; it has no effect on timing or state.

## Test plan
- WIDTH=4, reset high 2 cycles → all outputs 0, `busy`=0; then `num1`=1101, `num2`=0011, `start` 1 cycle → `busy` 4 cycles, `done` pulse 5 edges after acceptance, `quotient`=0100, `remainder`=0001, `div_by_zero`=0.
- `num1`=1111, `num2`=1111 → `quotient`=0001, `remainder`=0000. `num1`=0010, `num2`=0101 → `quotient`=0000, `remainder`=0010.
- `num1`=1001, `num2`=0000 → `done` 1 edge after acceptance, `busy` stays 0, `quotient`=1111, `remainder`=1001, `div_by_zero`=1. A following 0110/0010 clears the flag, giving `quotient`=0011, `remainder`=0000.
- Start 1110/0100, then assert `start` again with 0001/0001 two cycles later → second request ignored; single `done` with `quotient`=0011, `remainder`=0010.
- Start 1011/0010, assert `reset` on the 2nd RUN cycle → next cycle all outputs 0, IDLE, no `done`. A new start of 1011/0010 yields `quotient`=0101, `remainder`=0001.
- Exhaustive sweep, all 256 operand pairs, back-to-back at minimum spacing → invariant holds for every nonzero divisor, and the zero-divisor rule holds for every zero divisor.

Source files
------------

// File: rtl/divider_sequential_if.sv
// Start/busy/done handshake and operand/result bundle for divider_sequential.
// The controller drives the master side; the divider implements the slave side.
interface divider_sequential_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, num1, num2,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, num1, num2,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_sequential.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock; `DIVIDER_DISPLAY_EN prints each result.
// done pulses WIDTH+1 edges after acceptance (2 for a zero divisor); start is taken only in IDLE, never queued.
module divider_sequential #(
    parameter int WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    divider_sequential_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rmd;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic             r_zero_pend;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;
    logic             w_last;

    // The dividend register doubles as the quotient register: quotient bits shift in as dividend bits shift out.
    assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit    = ~w_trial[WIDTH];
    assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_last    = (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.num2 != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // A zero divisor spends one extra DONE cycle publishing its fixed result.
                if (!r_zero_pend) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_quo       <= '0;
            r_rmd       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dz        <= 1'b0;
            r_zero_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dvd       <= bus.num1;
                        r_dvs       <= bus.num2;
                        r_rem       <= '0;
                        r_cnt       <= CW'(WIDTH - 1);
                        r_busy      <= |bus.num2;
                        r_zero_pend <= ~|bus.num2;
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_dvd_nxt;
                    if (w_last) begin
                        r_quo  <= w_dvd_nxt;
                        r_rmd  <= w_rem_nxt;
                        r_dz   <= 1'b0;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (r_zero_pend) begin
                        r_quo       <= '1;
                        r_rmd       <= r_dvd;
                        r_dz        <= 1'b1;
                        r_done      <= 1'b1;
                        r_zero_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rmd;
    assign bus.div_by_zero = r_dz;

`ifdef DIVIDER_DISPLAY_EN
    logic [WIDTH-1:0] r_num1;

    always_ff @(posedge i_clk) begin
        if (r_state == IDLE && bus.start) begin
            r_num1 <= bus.num1;
        end
    end

    always @(posedge i_clk) begin
        if (!i_reset && r_done) begin
            $display("%b / %b = %b r %b%s", r_num1, r_dvs, r_quo, r_rmd, r_dz ? " DIV0" : "");
        end
    end
`endif
endmodule

// File: tb/tb_divider_sequential.sv
// Bench for divider_sequential (WIDTH=4): vector table, handshake corner sequences, exhaustive and random sweeps.
module tb_divider_sequential;
    localparam int W = 4;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    divider_sequential_if #(.WIDTH(W)) u_if ();

    divider_sequential #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Call while sitting at a negedge; returns at the negedge one cycle after done, i.e. ready to start again.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bsy, output int pulse_ok);
        u_if.start = 1'b1;
        u_if.num1  = a;
        u_if.num2  = b;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.num1  = W'($urandom);
        u_if.num2  = W'($urandom);
        lat = 1;
        bsy = int'(u_if.busy);
        while (!u_if.done && lat < 40) begin
            @(negedge clk);
            lat++;
            bsy += int'(u_if.busy);
        end
        @(negedge clk);
        pulse_ok = int'(!u_if.done);
    endtask

    // Reference: plain integer division, fixed result for a zero divisor.
    task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, bsy, pok;
        int eq, er, ez;
        do_div(a, b, lat, bsy, pok);
        if (b == 0) begin
            eq = (1 << W) - 1; er = int'(a); ez = 1;
        end else begin
            eq = int'(a) / int'(b); er = int'(a) % int'(b); ez = 0;
        end
        chk({tag, " quotient"},  int'(u_if.quotient),    eq);
        chk({tag, " remainder"}, int'(u_if.remainder),   er);
        chk({tag, " div0"},      int'(u_if.div_by_zero), ez);
        chk({tag, " latency"},   lat, (b == 0) ? 2 : W + 1);
        chk({tag, " busy"},      bsy, (b == 0) ? 0 : W);
        chk({tag, " pulse"},     pok, 1);
    endtask

    initial begin
        vec_t vecs[6];
        int   lat, bsy, pok, ndone, saw;

        vecs[0] = '{4'b1101, 4'b0011, 4'b0100, 4'b0001, 1'b0};
        vecs[1] = '{4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b0};
        vecs[2] = '{4'b0010, 4'b0101, 4'b0000, 4'b0010, 1'b0};
        vecs[3] = '{4'b1001, 4'b0000, 4'b1111, 4'b1001, 1'b1};
        vecs[4] = '{4'b0110, 4'b0010, 4'b0011, 4'b0000, 1'b0};
        vecs[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0};

        reset      = 1'b1;
        u_if.start = 1'b0;
        u_if.num1  = '0;
        u_if.num2  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", int'(u_if.busy), 0);
        chk("rst done", int'(u_if.done), 0);
        chk("rst quotient", int'(u_if.quotient), 0);
        chk("rst remainder", int'(u_if.remainder), 0);
        chk("rst div0", int'(u_if.div_by_zero), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_div(vecs[i].a, vecs[i].b, lat, bsy, pok);
            chk($sformatf("vec%0d quotient", i), int'(u_if.quotient), int'(vecs[i].q));
            chk($sformatf("vec%0d remainder", i), int'(u_if.remainder), int'(vecs[i].r));
            chk($sformatf("vec%0d div0", i), int'(u_if.div_by_zero), int'(vecs[i].z));
            chk($sformatf("vec%0d latency", i), lat, vecs[i].z ? 2 : W + 1);
            chk($sformatf("vec%0d busy", i), bsy, vecs[i].z ? 0 : W);
            chk($sformatf("vec%0d pulse", i), pok, 1);
        end

        // A second start two cycles into a run must be dropped.
        u_if.start = 1'b1; u_if.num1 = 4'b1110; u_if.num2 = 4'b0100;
        @(negedge clk);
        u_if.start = 1'b0;
        @(negedge clk);
        u_if.start = 1'b1; u_if.num1 = 4'b0001; u_if.num2 = 4'b0001;
        @(negedge clk);
        u_if.start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 14; c++) begin
            if (u_if.done) ndone++;
            @(negedge clk);
        end
        chk("ignore done count", ndone, 1);
        chk("ignore quotient", int'(u_if.quotient), 3);
        chk("ignore remainder", int'(u_if.remainder), 2);

        // Reset during the second RUN cycle abandons the operation.
        u_if.start = 1'b1; u_if.num1 = 4'b1011; u_if.num2 = 4'b0010;
        @(negedge clk);
        u_if.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst busy", int'(u_if.busy), 0);
        chk("midrst done", int'(u_if.done), 0);
        chk("midrst quotient", int'(u_if.quotient), 0);
        chk("midrst remainder", int'(u_if.remainder), 0);
        chk("midrst div0", int'(u_if.div_by_zero), 0);
        saw = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            saw += int'(u_if.done) + int'(u_if.busy);
        end
        chk("midrst quiet", saw, 0);
        check_op("after rst", 4'b1011, 4'b0010);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                check_op($sformatf("sweep %0d/%0d", a, b), W'(a), W'(b));
            end
        end

        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom_range(0, 15));
            check_op($sformatf("rand %0d/%0d", ra, rb), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
